fft_stage_scheduler: RTL and testbench
======================================

FFT_STAGE_SCHEDULER -- requirements
Module: fft_stage_scheduler

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: sample RAM index width.
REQ-002 Parameter MAX_LOG2N, default 12: largest supported transform, log2 of points.
REQ-003 Parameter MAX_OUTSTANDING, default 4: butterflies issued but not yet completed, upper bound.
REQ-004 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 i_rstn  in  1  asynchronous, active-low reset.
REQ-006 i_DATA_LOADED  in  1  one-cycle start pulse; sample RAM is full.
REQ-007 i_LOG2N  in  4  transform size L; N = 2^L; sampled only on an accepted start.
REQ-008 i_BF_READY  in  1  butterfly unit accepts the current request.
REQ-009 i_BF_DONE  in  1  one-cycle pulse; one butterfly result written back to RAM.
REQ-010 o_BF_VALID  out  1  butterfly request valid.
REQ-011 o_ADDR_A, o_ADDR_B  out  ADDR_WIDTH each  RAM indices of the butterfly pair.
REQ-012 o_TWIDDLE_IDX  out  ADDR_WIDTH-1  twiddle ROM index.
REQ-013 o_STAGE  out  4  current stage number.
REQ-014 o_BUSY  out  1  transform in progress.
REQ-015 o_CALC_END  out  1  one-cycle pulse; transform complete.
REQ-016 o_ERR  out  1  one-cycle pulse; start rejected.

Function
REQ-017 States: IDLE, ISSUE, DRAIN, DONE; encoding free; state, counters and outputs are registered or decoded from registers only.
REQ-018 IDLE: on i_DATA_LOADED with 1 <= i_LOG2N <= MAX_LOG2N, latch L, clear stage s and butterfly counter k, go to ISSUE; o_BUSY=1 from the next cycle.
REQ-019 IDLE: on i_DATA_LOADED with i_LOG2N == 0 or > MAX_LOG2N, pulse o_ERR for exactly one cycle in the following cycle and remain in IDLE.
REQ-020 i_DATA_LOADED outside IDLE is ignored; it does not restart, corrupt or error.
REQ-021 ISSUE: o_BF_VALID=1 while outstanding < MAX_OUTSTANDING, else 0.
REQ-022 Addressing, with half = 2^s, pos = k mod half, grp = k >> s: o_ADDR_A = grp*2*half + pos; o_ADDR_B = o_ADDR_A + half; o_TWIDDLE_IDX = pos << (L-1-s).
REQ-023 Handshake: a request is accepted on a cycle with o_BF_VALID & i_BF_READY; k then increments and outstanding increments.
REQ-024 Address outputs stay stable while o_BF_VALID=1 and not accepted.
REQ-025 The acceptance of k = N/2-1 moves the FSM to DRAIN; o_BF_VALID=0 in DRAIN.
REQ-026 Each i_BF_DONE decrements outstanding; simultaneous accept and done leaves outstanding unchanged.
REQ-027 i_BF_DONE with outstanding == 0 is ignored; no underflow.
REQ-028 DRAIN exits when outstanding == 0 (including the decrement in that cycle): if s == L-1 go to DONE, else s+1, k=0, go to ISSUE.
REQ-029 No butterfly of stage s+1 is issued before every stage-s butterfly has completed (stage barrier).
REQ-030 DONE: o_CALC_END=1 for exactly one cycle, then IDLE; o_BUSY=0 in DONE and IDLE.
REQ-031 o_STAGE = s in ISSUE and DRAIN; 0 otherwise.
REQ-032 Counter widths hold N/2-1 and MAX_OUTSTANDING without overflow at MAX_LOG2N.

Reset
REQ-033 i_rstn=0 asynchronously forces IDLE, s=k=outstanding=0, and all outputs 0, including mid-transform.
REQ-034 After reset release, the first i_DATA_LOADED starts a fresh transform; no residual state is kept.

Verification
REQ-035 L=2, i_BF_READY=1, i_BF_DONE one cycle after each accept -> (A,B,tw) sequence (0,1,0),(2,3,0), barrier, (0,2,0),(1,3,1); one o_CALC_END pulse.
REQ-036 L=3, i_BF_READY held 0 for 5 cycles in stage 1 -> o_ADDR_A=0, o_ADDR_B=2, o_TWIDDLE_IDX=0 held stable; 12 butterflies total; o_CALC_END once.
REQ-037 MAX_OUTSTANDING=4, i_BF_DONE withheld -> exactly 4 accepts, then o_BF_VALID=0 until the first i_BF_DONE.
REQ-038 i_LOG2N=0 and i_LOG2N=13 starts -> o_ERR one-cycle pulse each; o_BUSY stays 0.
REQ-039 L=12 run -> 12 stages x 2048 butterflies; last request A=2047, B=4095, tw=2047; no stage overlap.
REQ-040 Reset asserted mid-stage-1 plus a stray i_BF_DONE and i_DATA_LOADED while busy -> all outputs 0 immediately; clean L=2 run afterwards.

Source files
------------

// File: rtl/fft_stage_scheduler.sv
// Radix-2 FFT stage scheduler: walks stages and butterfly pairs, issues requests to a
// butterfly unit with a bounded number in flight, and enforces a barrier between stages.
module fft_stage_scheduler #(
   parameter int unsigned ADDR_WIDTH      = 12,
   parameter int unsigned MAX_LOG2N       = 12,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_DATA_LOADED,
   input  logic [3:0]            i_LOG2N,
   input  logic                  i_BF_READY,
   input  logic                  i_BF_DONE,
   output logic                  o_BF_VALID,
   output logic [ADDR_WIDTH-1:0] o_ADDR_A,
   output logic [ADDR_WIDTH-1:0] o_ADDR_B,
   output logic [ADDR_WIDTH-2:0] o_TWIDDLE_IDX,
   output logic [3:0]            o_STAGE,
   output logic                  o_BUSY,
   output logic                  o_CALC_END,
   output logic                  o_ERR
);

   localparam int unsigned KW   = (MAX_LOG2N > 1) ? MAX_LOG2N - 1 : 1;
   localparam int unsigned OW   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [3:0]  MAXL = 4'(MAX_LOG2N);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      l_q, l_d;
   logic [3:0]      s_q, s_d;
   logic [KW-1:0]   k_q, k_d;
   logic [OW-1:0]   out_q, out_d;
   logic            err_q, err_d;

   logic            in_issue, in_drain;
   logic            bf_valid, accept, done_ok, start_ok;
   logic [KW-1:0]   k_last;
   logic [OW-1:0]   out_next;

   logic [ADDR_WIDTH-1:0] k_ext, half, pos, grp, addr_a, addr_b;
   logic [ADDR_WIDTH-2:0] tw;
   logic [3:0]            tw_sh;

   assign in_issue = (state_q == S_ISSUE);
   assign in_drain = (state_q == S_DRAIN);
   assign bf_valid = in_issue && (out_q < OW'(MAX_OUTSTANDING));
   assign accept   = bf_valid && i_BF_READY;
   assign done_ok  = i_BF_DONE && (out_q != '0);
   assign start_ok = (i_LOG2N != 4'd0) && (i_LOG2N <= MAXL);
   assign k_last   = KW'((32'd1 << (l_q - 4'd1)) - 32'd1);
   assign out_next = out_q + OW'(accept) - OW'(done_ok);

   // Pair address: insert a zero bit at position s of k to form A; B sets that bit.
   always_comb begin
      k_ext  = ADDR_WIDTH'(k_q);
      half   = ADDR_WIDTH'(1) << s_q;
      pos    = k_ext & (half - ADDR_WIDTH'(1));
      grp    = k_ext >> s_q;
      addr_a = (grp << (s_q + 4'd1)) | pos;
      addr_b = addr_a + half;
      tw_sh  = l_q - 4'd1 - s_q;
      tw     = pos[ADDR_WIDTH-2:0] << tw_sh;
   end

   always_comb begin
      state_d = state_q;
      l_d     = l_q;
      s_d     = s_q;
      k_d     = k_q;
      out_d   = out_next;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_DATA_LOADED) begin
               if (start_ok) begin
                  l_d     = i_LOG2N;
                  s_d     = '0;
                  k_d     = '0;
                  state_d = S_ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (accept) begin
               if (k_q == k_last) state_d = S_DRAIN;
               else               k_d     = k_q + KW'(1);
            end
         end
         S_DRAIN: begin
            // Barrier: next stage only once every issued butterfly has written back.
            if (out_next == '0) begin
               if (s_q == l_q - 4'd1) begin
                  state_d = S_DONE;
               end else begin
                  s_d     = s_q + 4'd1;
                  k_d     = '0;
                  state_d = S_ISSUE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= S_IDLE;
         l_q     <= '0;
         s_q     <= '0;
         k_q     <= '0;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         l_q     <= l_d;
         s_q     <= s_d;
         k_q     <= k_d;
         out_q   <= out_d;
         err_q   <= err_d;
      end
   end

   assign o_BF_VALID    = bf_valid;
   assign o_ADDR_A      = in_issue ? addr_a : '0;
   assign o_ADDR_B      = in_issue ? addr_b : '0;
   assign o_TWIDDLE_IDX = in_issue ? tw : '0;
   assign o_STAGE       = (in_issue || in_drain) ? s_q : '0;
   assign o_BUSY        = in_issue || in_drain;
   assign o_CALC_END    = (state_q == S_DONE);
   assign o_ERR         = err_q;

endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Scoreboard bench for fft_stage_scheduler: expected requests are queued at stimulus time
// and popped by a monitor on every accepted butterfly.
module tb_fft_stage_scheduler;

   logic        clk = 1'b0;
   logic        rstn, dl, rdy, bf_done;
   logic [3:0]  log2n;
   logic        bf_valid, busy, calc_end, err;
   logic [11:0] addr_a, addr_b;
   logic [10:0] tw_idx;
   logic [3:0]  stage;

   always #5 clk = ~clk;

   fft_stage_scheduler #(
      .ADDR_WIDTH(12),
      .MAX_LOG2N(12),
      .MAX_OUTSTANDING(4)
   ) dut (
      .i_clk(clk),
      .i_rstn(rstn),
      .i_DATA_LOADED(dl),
      .i_LOG2N(log2n),
      .i_BF_READY(rdy),
      .i_BF_DONE(bf_done),
      .o_BF_VALID(bf_valid),
      .o_ADDR_A(addr_a),
      .o_ADDR_B(addr_b),
      .o_TWIDDLE_IDX(tw_idx),
      .o_STAGE(stage),
      .o_BUSY(busy),
      .o_CALC_END(calc_end),
      .o_ERR(err)
   );

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic [10:0] tw;
      logic [3:0]  st;
   } req_t;

   req_t exp_q[$];
   req_t r;
   int   total = 0, bad = 0;
   int   acc_count = 0, calc_seen = 0, out_m = 0, pend_done = 0, last_stage = 0;
   bit   auto_done = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic void push(input int a, input int b, input int t, input int st);
      req_t e;
      e.a  = 12'(a);
      e.b  = 12'(b);
      e.tw = 11'(t);
      e.st = 4'(st);
      exp_q.push_back(e);
   endfunction

   // Group-major enumeration; twiddle stride is N/(2*half).
   task automatic push_model(input int l);
      int n, half, groups;
      n = 1 << l;
      for (int s = 0; s < l; s++) begin
         half   = 1 << s;
         groups = n / (2 * half);
         for (int g = 0; g < groups; g++)
            for (int p = 0; p < half; p++)
               push(g * 2 * half + p, g * 2 * half + p + half, p * groups, s);
      end
   endtask

   task automatic push_l2();
      push(0, 1, 0, 0); push(2, 3, 0, 0);
      push(0, 2, 0, 1); push(1, 3, 1, 1);
   endtask

   task automatic push_l3();
      push(0, 1, 0, 0); push(2, 3, 0, 0); push(4, 5, 0, 0); push(6, 7, 0, 0);
      push(0, 2, 0, 1); push(1, 3, 2, 1); push(4, 6, 0, 1); push(5, 7, 2, 1);
      push(0, 4, 0, 2); push(1, 5, 1, 2); push(2, 6, 2, 2); push(3, 7, 3, 2);
   endtask

   // Monitor: samples on the falling edge what the next rising edge will commit.
   always @(negedge clk) begin
      if (rstn === 1'b1) begin
         if (bf_valid) chk("outstanding_limit", 64'(out_m < 4), 64'd1);
         if (bf_valid && rdy) begin
            acc_count++;
            if (exp_q.size() == 0) begin
               chk("unexpected_request", 64'(exp_q.size()), 64'd1);
            end else begin
               r = exp_q.pop_front();
               chk("addr_a", 64'(addr_a), 64'(r.a));
               chk("addr_b", 64'(addr_b), 64'(r.b));
               chk("twiddle", 64'(tw_idx), 64'(r.tw));
               chk("stage", 64'(stage), 64'(r.st));
               if (int'(stage) != last_stage) begin
                  chk("stage_barrier", 64'(out_m), 64'd0);
                  last_stage = int'(stage);
               end
            end
            if (auto_done) pend_done++;
            out_m++;
         end
         if (bf_done && out_m > 0) out_m--;
         if (calc_end) begin
            calc_seen++;
            chk("busy_at_end", 64'(busy), 64'd0);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (pend_done > 0) begin
         bf_done = 1'b1;
         pend_done--;
      end else begin
         bf_done = 1'b0;
      end
   end

   task automatic start(input logic [3:0] l);
      @(posedge clk); #1;
      dl    = 1'b1;
      log2n = l;
      @(posedge clk); #1;
      dl    = 1'b0;
   endtask

   task automatic wait_end(input int budget);
      int c0, n;
      c0 = calc_seen;
      n  = 0;
      while (calc_seen == c0 && n < budget) begin
         @(negedge clk); #1;
         n++;
      end
      chk("calc_end_seen", 64'(calc_seen), 64'(c0 + 1));
      @(negedge clk); #1;
      chk("calc_end_single", 64'(calc_end), 64'd0);
      chk("calc_end_count", 64'(calc_seen), 64'(c0 + 1));
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 64'(bf_valid), 64'd0);
      chk({tag, "_addr_a"}, 64'(addr_a), 64'd0);
      chk({tag, "_addr_b"}, 64'(addr_b), 64'd0);
      chk({tag, "_tw"}, 64'(tw_idx), 64'd0);
      chk({tag, "_stage"}, 64'(stage), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_calc_end"}, 64'(calc_end), 64'd0);
      chk({tag, "_err"}, 64'(err), 64'd0);
   endtask

   initial begin
      int acc0, n;
      rstn = 1'b0; dl = 1'b0; log2n = 4'd0; rdy = 1'b0; bf_done = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk_all_zero("reset");
      @(posedge clk); #1;
      rstn = 1'b1;

      // L=2 back-to-back with completion one cycle after each accept
      push_l2();
      rdy = 1'b1; auto_done = 1'b1; last_stage = 0;
      start(4'd2);
      @(negedge clk); #1;
      chk("busy_after_start", 64'(busy), 64'd1);
      wait_end(200);

      // L=3 with a 5-cycle ready stall on the first stage-1 request
      push_l3();
      acc0 = acc_count; last_stage = 0;
      start(4'd3);
      n = 0;
      while (acc_count < acc0 + 4 && n < 50) begin @(negedge clk); #1; n++; end
      chk("l3_stage0_accepts", 64'(acc_count), 64'(acc0 + 4));
      @(posedge clk); #1;
      rdy = 1'b0;
      n = 0;
      while (!bf_valid && n < 20) begin @(negedge clk); #1; n++; end
      chk("stall_valid_seen", 64'(bf_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         chk("stall_addr_a", 64'(addr_a), 64'd0);
         chk("stall_addr_b", 64'(addr_b), 64'd2);
         chk("stall_tw", 64'(tw_idx), 64'd0);
         chk("stall_valid", 64'(bf_valid), 64'd1);
         if (i < 4) begin @(negedge clk); #1; end
      end
      @(posedge clk); #1;
      rdy = 1'b1;
      wait_end(300);
      chk("l3_total_accepts", 64'(acc_count), 64'(acc0 + 12));

      // L=4 with completions withheld: exactly MAX_OUTSTANDING accepts, then stall
      push_model(4);
      auto_done = 1'b0; acc0 = acc_count; last_stage = 0;
      start(4'd4);
      n = 0;
      while (acc_count < acc0 + 4 && n < 20) begin @(negedge clk); #1; n++; end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         chk("withheld_valid", 64'(bf_valid), 64'd0);
      end
      chk("withheld_accepts", 64'(acc_count), 64'(acc0 + 4));
      pend_done += 1;
      auto_done  = 1'b1;
      n = 0;
      while (!bf_valid && n < 6) begin @(negedge clk); #1; n++; end
      chk("valid_after_done", 64'(bf_valid), 64'd1);
      pend_done += 3;
      wait_end(500);

      // Rejected starts
      for (int i = 0; i < 2; i++) begin
         start((i == 0) ? 4'd0 : 4'd13);
         @(negedge clk); #1;
         chk("err_pulse", 64'(err), 64'd1);
         chk("err_busy", 64'(busy), 64'd0);
         @(negedge clk); #1;
         chk("err_cleared", 64'(err), 64'd0);
         chk("err_still_idle", 64'(busy), 64'd0);
      end

      // Full-size transform
      push_model(12);
      acc0 = acc_count; last_stage = 0;
      start(4'd12);
      wait_end(30000);
      chk("l12_total_accepts", 64'(acc_count), 64'(acc0 + 12 * 2048));

      // Reset mid-stage-1 with stray start and completion while busy
      push_l3();
      last_stage = 0;
      start(4'd3);
      n = 0;
      while (stage != 4'd1 && n < 100) begin @(negedge clk); #1; n++; end
      chk("reached_stage1", 64'(stage), 64'd1);
      start(4'd2);
      @(negedge clk); #1;
      chk("ignored_start_err", 64'(err), 64'd0);
      chk("ignored_start_busy", 64'(busy), 64'd1);
      chk("ignored_start_stage", 64'(stage), 64'd1);
      pend_done += 1;
      @(negedge clk); #1;
      rstn = 1'b0;
      #1;
      chk_all_zero("midreset");
      exp_q.delete();
      pend_done = 0; out_m = 0; auto_done = 1'b0; last_stage = 0; rdy = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      push_l2();
      rdy = 1'b1; auto_done = 1'b1;
      start(4'd2);
      wait_end(200);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
